sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Bridges the memory-stage load/store interface to the external 32-bit SRAM pins (sram_address, sram_dq, sram_we_n).
//  Converts a byte address into a word index. Holds address and data stable for a fixed number of wait cycles.
//  Captures read data and drives ready low so the pipeline freezes until each access completes.
//  Sits between the MEM stage and the board SRAM (or its simulation model).
// PARAMETERS
//  ADDR_W       17    SRAM word-address width
//  DATA_W       32    SRAM data width
//  WAIT_CYCLES  5     cycles each access holds the pins; must be >= 1 and must cover the SRAM read delay
//  BASE_ADDR    1024  byte address that maps to SRAM word 0
// PORTS
//  clk           in     1       system clock; all state updates on rising edge
//  rst           in     1       synchronous, active-high reset
//  wr_en         in     1       store request; held by the requester until ready=1
//  rd_en         in     1       load request; held by the requester until ready=1
//  address       in     32      byte address of the access
//  write_data    in     DATA_W  store data
//  read_data     out    DATA_W  load result (registered)
//  ready         out    1       1 = no access pending or access done; 0 = pipeline must freeze
//  sram_address  out    ADDR_W  SRAM word address (registered)
//  sram_we_n     out    1       SRAM write enable, active low (registered)
//  sram_dq       inout  DATA_W  SRAM data bus
// BEHAVIOUR
//  - Reset (synchronous, on rst=1 at a clock edge) sets:
//    - state=IDLE, count=0, sram_we_n=1, sram_address=0, read_data=0.
//    - write-data latch=0; sram_dq released (Z).
//  - States: IDLE, WRITE, READ, DONE.
//  - IDLE:
//    - If wr_en=1, go to WRITE; else if rd_en=1, go to READ. Write wins when both are set.
//    - On acceptance, latch sram_address and write_data, and set count=0.
//  - WRITE:
//    - sram_we_n=0 and sram_dq=latched write_data for exactly WAIT_CYCLES cycles.
//    - count increments each cycle; at count==WAIT_CYCLES-1 go to DONE.
//  - READ:
//    - sram_we_n=1 and sram_dq=Z for WAIT_CYCLES cycles.
//    - On the edge leaving the last READ cycle (count==WAIT_CYCLES-1), sample sram_dq into read_data and go to DONE.
//  - DONE: one cycle, then IDLE unconditionally. sram_we_n=1, sram_dq=Z.
//  - ready (combinational) = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en).
//  - Latency: request seen in IDLE at cycle 0; cycles 1..WAIT_CYCLES are the access; ready=1 in cycle WAIT_CYCLES+1.
//  - read_data holds its value until the next read completes. Writes never alter read_data.
//  - Address mapping: sram_address = ((address - BASE_ADDR) >> 2), truncated to ADDR_W.
//    - address[1:0] is ignored.
//    - Addresses below BASE_ADDR wrap modulo 2^ADDR_W; no error is flagged.
//  - sram_we_n is 0 only in WRITE, and sram_dq is driven only in WRITE, so there is no bus contention with the SRAM.
//  - Request dropped mid-access: the access still completes and DONE still pulses ready.
//  - The DONE->IDLE cycle never re-issues the finished request. A new request is accepted in IDLE the cycle after DONE.
//  - rst mid-access: abort immediately; sram_we_n=1 on the next edge. Words the SRAM already wrote are kept.
// TESTING (WAIT_CYCLES=5, BASE_ADDR=1024, SRAM model attached)
//  - Reset: rst=1 for 2 cycles -> sram_we_n=1, sram_dq=Z, read_data=0, ready=1 with no request.
//  - Write 0xDEADBEEF to 1024:
//    - sram_address=0; sram_we_n=0 for exactly 5 cycles.
//    - ready=0 for 6 cycles, then 1 for 1 cycle.
//  - Read 1024 after that write -> read_data=0xDEADBEEF in the DONE cycle; value held for 10 further idle cycles.
//  - Back-to-back: write 0x12345678 to 1028, then read 1028 on the cycle after DONE -> sram_address=1, read_data=0x12345678.
//  - rd_en=wr_en=1 to 1032 with write_data=0xA5A5A5A5:
//    - a write is performed; read_data is unchanged.
//    - a later read of 1032 returns 0xA5A5A5A5.
//  - rst at cycle 3 of a write -> sram_we_n=1, state=IDLE, ready=1 on the next edge; no DONE pulse.

Source files
------------

// File: rtl/sram_controller.sv
// Memory-stage bridge to a 32-bit asynchronous SRAM: holds address/data for WAIT_CYCLES
// per access and freezes the pipeline (ready=0) until the access finishes.
module sram_controller #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_we_n,
  inout  wire  [DATA_W-1:0] sram_dq
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [DATA_W-1:0]   wdata_lat;
  logic                last_cycle;
  logic                accept;
  logic [31:0]         addr_off;
  logic [ADDR_W-1:0]   word_idx;
  logic                unused_addr_bits;

  // Byte offset from the SRAM window base; the two low bits select a byte and are dropped.
  assign addr_off         = address - 32'(BASE_ADDR);
  assign word_idx         = addr_off[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr_off[31:ADDR_W+2], addr_off[1:0]};

  assign last_cycle = (count == CNT_W'(WAIT_CYCLES - 1));
  assign accept     = (state == IDLE) && (wr_en || rd_en);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (wr_en)      state_nxt = WRITE;
        else if (rd_en) state_nxt = READ;
      end
      WRITE, READ: begin
        if (last_cycle) state_nxt = DONE;
        else            count_nxt = count + 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      sram_we_n    <= 1'b1;
      sram_address <= '0;
      read_data    <= '0;
      wdata_lat    <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      // Registered strobe tracks the next state so it is low exactly while in WRITE.
      sram_we_n <= (state_nxt != WRITE);
      if (accept) begin
        sram_address <= word_idx;
        wdata_lat    <= write_data;
      end
      if (state == READ && last_cycle)
        read_data <= sram_dq;
    end
  end

  // Bus is driven only while the write strobe is low, so the SRAM never sees contention.
  assign sram_dq = (state == WRITE) ? wdata_lat : {DATA_W{1'bz}};

  assign ready = (state == DONE) || ((state == IDLE) && !rd_en && !wr_en);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM attached to the pins.
module tb_sram_controller;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WAITC  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [31:0]       address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic [DATA_W-1:0] read_data;
  logic              ready;
  logic [ADDR_W-1:0] sram_address;
  logic              sram_we_n;
  wire  [DATA_W-1:0] sram_dq;

  int n_cmp = 0;
  int n_bad = 0;

  sram_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAITC), .BASE_ADDR(1024)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_address(sram_address), .sram_we_n(sram_we_n), .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;

  // SRAM model: writes on clock edges while we_n is low, drives read data otherwise.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_address[7:0]] <= sram_dq;
  end
  assign sram_dq = sram_we_n ? mem[sram_address[7:0]] : 32'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one access from the next falling edge; reports cycles with ready low,
  // cycles with we_n low, the SRAM address during the access and read_data in DONE.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int rdy_low, output int we_low,
                        output logic [31:0] adr, output logic [31:0] rdat);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    rdy_low = 0; we_low = 0; adr = '1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready) break;
      rdy_low++;
      if (!sram_we_n) we_low++;
      if (i == 1) adr = 32'(sram_address);
      @(negedge clk);
    end
    rdat = read_data;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_adr;
    int          exp_rdy_low;
    int          exp_we_low;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rl, wl;
    logic [31:0] adr, rdat, held;

    vecs.push_back('{"wr_1024",   1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0,     6, 5, 32'h0});
    vecs.push_back('{"rd_1024",   1'b0, 1'b1, 32'd1024, 32'h0,        32'd0,     6, 0, 32'hDEADBEEF});
    vecs.push_back('{"wr_1028",   1'b1, 1'b0, 32'd1028, 32'h12345678, 32'd1,     6, 5, 32'hDEADBEEF});
    vecs.push_back('{"rd_1028",   1'b0, 1'b1, 32'd1028, 32'h0,        32'd1,     6, 0, 32'h12345678});
    vecs.push_back('{"both_1032", 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'd2,     6, 5, 32'h12345678});
    vecs.push_back('{"rd_1032",   1'b0, 1'b1, 32'd1032, 32'h0,        32'd2,     6, 0, 32'hA5A5A5A5});
    vecs.push_back('{"wr_wrap",   1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 32'h1FFFF, 6, 5, 32'hA5A5A5A5});
    vecs.push_back('{"rd_wrap",   1'b0, 1'b1, 32'd1020, 32'h0,        32'h1FFFF, 6, 0, 32'h0BADF00D});
    vecs.push_back('{"rd_1027",   1'b0, 1'b1, 32'd1027, 32'h0,        32'd0,     6, 0, 32'hDEADBEEF});

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sram_address", 32'(sram_address), 32'd0);

    foreach (vecs[k]) begin
      access(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, rl, wl, adr, rdat);
      chk({vecs[k].name, "_ready_low"}, 32'(rl), 32'(vecs[k].exp_rdy_low));
      chk({vecs[k].name, "_we_low"}, 32'(wl), 32'(vecs[k].exp_we_low));
      chk({vecs[k].name, "_sram_addr"}, adr, vecs[k].exp_adr);
      chk({vecs[k].name, "_read_data"}, rdat, vecs[k].exp_rdata);
    end

    // read_data holds through idle cycles
    held = read_data;
    chk("hold_value", held, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("hold_read_data", read_data, 32'hDEADBEEF);
      chk("hold_idle_ready", 32'(ready), 32'd1);
    end

    // Request withdrawn mid-write still completes with a DONE pulse
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h5555AAAA;
    rl = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready) break;
      rl++;
      if (i == 2) wr_en = 1'b0;
      @(negedge clk);
    end
    chk("drop_ready_low", 32'(rl), 32'd6);
    access(1'b0, 1'b1, 32'd1036, 32'h0, rl, wl, adr, rdat);
    chk("drop_readback", rdat, 32'h5555AAAA);
    chk("drop_readback_lat", 32'(rl), 32'd6);

    // Reset in the third cycle of a write aborts it immediately
    held = read_data;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h77777777;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_we_low_before", 32'(sram_we_n), 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk); #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_read_data", read_data, 32'h0);
    rst = 1'b0;
    wr_en = 1'b1; #1;
    chk("abort_idle_accepts", 32'(ready), 32'd0);
    wr_en = 1'b0; #1;
    chk("abort_no_done", 32'(ready), 32'd1);
    access(1'b0, 1'b1, 32'd1040, 32'h0, rl, wl, adr, rdat);
    chk("abort_kept_word", rdat, 32'h77777777);
    chk("abort_next_lat", 32'(rl), 32'd6);
    chk("abort_next_addr", adr, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
